// File: rtl/ahb_rr_lock_arbiter.sv
// Registered AHB bus arbiter: round-robin or fixed priority, grant held across
// locked sequences, hold-time pre-emption and parking on a default master.
module ahb_rr_lock_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int ID_W       = 2,
  parameter int RR_MODE    = 1,
  parameter int MAX_HOLD   = 16,
  parameter int DEF_MASTER = 0
) (
  input  logic                            i_bus_clk,
  input  logic                            i_bus_rstn,
  input  logic [MASTER_NUM-1:0]           i_master_req,
  input  logic [MASTER_NUM-1:0]           i_master_lock,
  input  logic                            i_bus_hready,
  output logic [MASTER_NUM-1:0]           o_master_grant,
  output logic [ID_W-1:0]                 o_master_id,
  output logic                            o_grant_valid,
  output logic [$clog2(MAX_HOLD+1)-1:0]   o_hold_cnt
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);
  localparam logic [MASTER_NUM-1:0] DEF_OH   = MASTER_NUM'(1) << DEF_MASTER;
  localparam logic [HC_W-1:0]       HOLD_MAX = HC_W'(MAX_HOLD);

  typedef enum logic {PARK, OWN} state_t;

  state_t                  state_q, state_d;
  logic [MASTER_NUM-1:0]   grant_q, grant_d;
  logic [MASTER_NUM-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [HC_W-1:0]         hold_q, hold_d;

  logic                    owner_req, owner_lock, others_req;
  logic                    timeout, rearb;
  logic [MASTER_NUM-1:0]   cand, win;
  logic [ID_W-1:0]         win_id;

  assign owner_req  = |(i_master_req & grant_q);
  assign owner_lock = |(i_master_lock & grant_q);
  assign others_req = |(i_master_req & ~grant_q);

  // A locked owner is never pre-empted; only dropping its request releases it.
  assign timeout = (state_q == OWN) & owner_req & ~owner_lock &
                   (hold_q == HOLD_MAX) & others_req;
  assign rearb   = ((state_q == PARK) & (|i_master_req)) |
                   ((state_q == OWN) & ~owner_req) | timeout;
  assign cand    = timeout ? (i_master_req & ~grant_q) : i_master_req;

  generate
    if (RR_MODE != 0) begin : g_rr
      logic [2*MASTER_NUM-1:0] dbl, dbl_win;
      // Double-width trick: the carry out of ~req + ptr lands on the first
      // requester at or above the pointer, wrapping via the upper copy.
      assign dbl     = {cand, cand};
      assign dbl_win = dbl & (~dbl + {{MASTER_NUM{1'b0}}, ptr_q});
      assign win     = dbl_win[MASTER_NUM-1:0] | dbl_win[2*MASTER_NUM-1:MASTER_NUM];
    end else begin : g_fp
      assign win = cand & (~cand + MASTER_NUM'(1));
    end
  endgenerate

  always_comb begin
    win_id = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (win[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (i_bus_hready) begin
      if (rearb) begin
        hold_d = '0;
        if (|cand) begin
          state_d = OWN;
          grant_d = win;
          id_d    = win_id;
          ptr_d   = {win[MASTER_NUM-2:0], win[MASTER_NUM-1]};
        end else begin
          state_d = PARK;
          grant_d = DEF_OH;
          id_d    = ID_W'(DEF_MASTER);
        end
      end else if (state_q == OWN) begin
        if (hold_q != HOLD_MAX) hold_d = hold_q + HC_W'(1);
      end else begin
        hold_d = '0;
      end
    end
  end

  always_ff @(posedge i_bus_clk or negedge i_bus_rstn) begin
    if (!i_bus_rstn) begin
      state_q <= PARK;
      grant_q <= DEF_OH;
      id_q    <= ID_W'(DEF_MASTER);
      ptr_q   <= MASTER_NUM'(1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign o_master_grant = grant_q;
  assign o_master_id    = id_q;
  assign o_grant_valid  = (state_q == OWN);
  assign o_hold_cnt     = hold_q;

endmodule

// File: doc/ahb_rr_lock_arbiter.md
# ahb_rr_lock_arbiter

Registered AHB bus arbiter for MASTER_NUM masters, selectable between round-robin and fixed priority. A grant is held across bursts and locked sequences and changes hands only on an AHB transfer boundary (`i_bus_hready` high). A hold-time limit stops a non-locked master from starving the others. Idle ownership is parked on a default master. It sits between the master request lines and the AHB address/control mux, and drives both the one-hot grant and the encoded owner ID for mux select.

## Interface

Parameters:
- `MASTER_NUM`, 4: number of masters; must be at least 2.
- `ID_W`, 2: width of `o_master_id`; equals clog2(MASTER_NUM).
- `RR_MODE`, 1: 1 selects round-robin, 0 selects fixed priority (index 0 highest).
- `MAX_HOLD`, 16: number of `i_bus_hready`-high cycles after which a non-locked owner may be pre-empted; must be at least 1.
- `DEF_MASTER`, 0: park master index; must be below MASTER_NUM.

Ports:
- `i_bus_clk`, input, 1: bus clock; all state changes on the rising edge.
- `i_bus_rstn`, input, 1: asynchronous, active-low reset.
- `i_master_req`, input, MASTER_NUM: per-master bus request, level.
- `i_master_lock`, input, MASTER_NUM: per-master locked-transfer request; meaningful only for the current owner.
- `i_bus_hready`, input, 1: AHB HREADY; high marks a transfer boundary.
- `o_master_grant`, output, MASTER_NUM: registered one-hot grant; always exactly one bit set.
- `o_master_id`, output, ID_W: binary index of the granted master.
- `o_grant_valid`, output, 1: 1 means the granted master is requesting (state OWN); 0 means parked.
- `o_hold_cnt`, output, clog2(MAX_HOLD+1): current owner hold counter, for debug.

## Operation

State machine has two states: PARK and OWN.

- **Reset values:** state PARK; `o_master_grant` = one-hot(DEF_MASTER); `o_master_id` = DEF_MASTER; `o_grant_valid` = 0; hold counter = 0; RR pointer = one-hot bit 0.
- **Rearbitration condition** (evaluated each cycle; acts only when `i_bus_hready`=1). Any of the following:
  - State PARK and `i_master_req` non-zero.
  - State OWN and the owner's req bit = 0.
  - State OWN, owner's lock bit = 0, hold counter = MAX_HOLD, and some other master requesting.
- **Lock:** when the owner's lock bit is 1, the timeout is ignored. Only dropping req releases a locked owner.
- **Candidate set:** `i_master_req`. In the timeout-forced case, the owner's bit is removed from the candidate set.
- **RR winner:** first candidate at or above the pointer position, wrapping through index MASTER_NUM-1 to 0. Implementation: double-width request masked by (~request + pointer), then fold the two halves.
- **Fixed-priority winner (RR_MODE=0):** lowest-index candidate.
- **Candidate set non-empty:** grant <= winner one-hot; id <= winner index; state <= OWN; hold counter <= 0; RR pointer <= rotate-left(winner one-hot) by 1, wrapping at MASTER_NUM-1.
- **Candidate set empty** (owner dropped, no one else requesting): grant <= one-hot(DEF_MASTER); state <= PARK; valid <= 0; pointer unchanged.
- **Hold counter:** in OWN with no rearbitration, it increments on each `i_bus_hready`=1 cycle and saturates at MAX_HOLD. It holds its value when `i_bus_hready`=0. It is 0 in PARK.
- **When `i_bus_hready`=0:** grant, id, state and pointer all hold, regardless of req or lock changes.
- **Same master re-granted:** if a rearbitration re-selects the current owner, the hold counter still clears.
- **Reset asserted mid-operation:** all outputs return to their reset values immediately (asynchronously). Operation resumes from PARK on the first edge after release.

## Timing

- Grant latency is 1 cycle. Rearbitration condition true at edge N results in new `o_master_grant` and `o_master_id` visible after edge N, i.e. in cycle N+1.
- `o_master_grant`, `o_master_id` and `o_grant_valid` are purely registered: no combinational path from any input to any output.
- Requests rising while `i_bus_hready`=0 are recognised at the first edge with `i_bus_hready`=1.
- Simultaneous owner req drop and another master's req rise in the same cycle hand over directly OWN to OWN, with no PARK cycle.
- Timeout pre-emption occurs at the first `i_bus_hready`=1 edge at which the counter already equals MAX_HOLD. So with `i_bus_hready` held high, a non-locked owner keeps the bus for MAX_HOLD+1 cycles when contended.

## Test plan

Defaults throughout (N=4, RR, MAX_HOLD=16, DEF_MASTER=0) unless stated; `i_bus_hready`=1 unless stated.

1. **Reset and park:** release reset with req=0000 -> grant=0001, id=0, valid=0, hold_cnt=0 for 10 cycles.
2. **Round-robin rotation:** req=1111, each owner drops req for 1 cycle after 3 cycles of ownership -> grant sequence 0001, 0010, 0100, 1000, 0001; each grant change lands exactly one cycle after the drop.
3. **Timeout and lock:**
   - Master 1 owns with lock=0 and req=1010 constant -> grant moves to 1000 after 17 cycles of ownership.
   - Repeat with lock[1]=1 -> grant stays 0010 for 100 cycles.
   - Then drop lock[1] -> grant moves to 1000 at the first edge where hold_cnt=16, i.e. in the cycle after that edge.
4. **HREADY stall:** owner 2 drops req while `i_bus_hready`=0 for 5 cycles with req[3]=1 -> grant stays 0100 during the stall, becomes 1000 one cycle after `i_bus_hready` rises; hold_cnt frozen during the stall.
5. **Fixed priority** (RR_MODE=0):
   - req=0110 -> grant 0010.
   - Owner times out -> grant 0100 (owner excluded from candidates).
   - req[0] rises while 0100 owns, unlocked -> pre-empted only at timeout, then grant 0001.
6. **Asynchronous reset mid-burst:** assert `i_bus_rstn` low between clock edges while master 3 owns -> outputs go to grant=0001, valid=0 immediately, without waiting for a clock edge. After release with req=1000 -> grant=1000 one cycle later and RR pointer restarts from bit 0.
